// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states and
// helper functions for lane masks, store replication and alignment checks.
package memory_access_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   function automatic logic is_load(input logic [3:0] op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
             (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
      logic half, word;
      half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
      word = (op == MEM_LW) || (op == MEM_SW);
      return (half && a[0]) || (word && (a != 2'b00));
   endfunction

   function automatic logic [3:0] byte_mask(input logic [3:0] op, input logic [1:0] a);
      logic [3:0] m;
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: m = 4'b0001 << a;
         MEM_LH, MEM_LHU, MEM_SH: m = 4'b0011 << {a[1], 1'b0};
         default:                 m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
      logic [31:0] w;
      case (op)
         MEM_SB:  w = {4{d[7:0]}};
         MEM_SH:  w = {2{d[15:0]}};
         MEM_SW:  w = d;
         default: w = 32'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load formatter: picks the addressed lane out of a read word and
// sign- or zero-extends it. Kept standalone so a cache front end can reuse it.
module memory_access_load_align
   import memory_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [3:0]  op,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      case (addr_lo)
         2'd0: byte_v = rdata[7:0];
         2'd1: byte_v = rdata[15:8];
         2'd2: byte_v = rdata[23:16];
         2'd3: byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      result = rdata;
      case (op)
         MEM_LB:  result = {{24{byte_v[7]}}, byte_v};
         MEM_LBU: result = {24'd0, byte_v};
         MEM_LH:  result = {{16{half_v[15]}}, half_v};
         MEM_LHU: result = {16'd0, half_v};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues RV32I loads/stores over a req/ack port,
// stalls upstream while waiting, and emits a one-cycle write-back pulse.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_pipeline_ctl_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [3:0]  mem_op,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_busy,
   output logic [31:0] wb_data,
   output logic        mem_pipeline_ctl_out,
   output logic        misaligned,
   output logic        bus_error
);

   // state   | meaning
   // ST_IDLE | accepting a new op from execute
   // ST_WAIT | request outstanding, waiting for dmem_ack or timeout

   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     op_q, op_d;
   logic [1:0]     addr_lo_q, addr_lo_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    wb_data_q, wb_data_d;
   logic           ctl_out_q, ctl_out_d;
   logic           misaligned_q, misaligned_d;
   logic           bus_error_q, bus_error_d;
   logic [31:0]    load_result;
   logic           timeout;

   memory_access_load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_lo_q),
      .op      (op_q),
      .result  (load_result)
   );

   // The ack check has priority, so an ack on the last allowed cycle still completes.
   assign timeout = (MAX_WAIT != 0) && (cnt_q == CW'(MAX_WAIT - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      addr_lo_d    = addr_lo_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      wb_data_d    = wb_data_q;
      ctl_out_d    = DISABLE;
      misaligned_d = DISABLE;
      bus_error_d  = DISABLE;

      case (state_q)
         ST_IDLE: begin
            if (mem_pipeline_ctl_in) begin
               if (!is_load(mem_op) && !is_store(mem_op)) begin
                  wb_data_d = alu_result;
                  ctl_out_d = ENABLE;
               end else if (is_misaligned(mem_op, alu_result[1:0])) begin
                  wb_data_d    = 32'd0;
                  misaligned_d = ENABLE;
                  ctl_out_d    = ENABLE;
               end else begin
                  req_d     = ENABLE;
                  we_d      = is_store(mem_op);
                  addr_d    = {alu_result[31:2], 2'b00};
                  addr_lo_d = alu_result[1:0];
                  be_d      = byte_mask(mem_op, alu_result[1:0]);
                  wdata_d   = store_lanes(mem_op, store_data);
                  op_d      = mem_op;
                  cnt_d     = '0;
                  state_d   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_ack) begin
               req_d     = DISABLE;
               state_d   = ST_IDLE;
               ctl_out_d = ENABLE;
               wb_data_d = we_q ? 32'd0 : load_result;
            end else if (timeout) begin
               req_d       = DISABLE;
               state_d     = ST_IDLE;
               ctl_out_d   = ENABLE;
               bus_error_d = ENABLE;
               wb_data_d   = 32'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         addr_lo_q    <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         wb_data_q    <= '0;
         ctl_out_q    <= 1'b0;
         misaligned_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         addr_lo_q    <= addr_lo_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         wb_data_q    <= wb_data_d;
         ctl_out_q    <= ctl_out_d;
         misaligned_q <= misaligned_d;
         bus_error_q  <= bus_error_d;
      end
   end

   assign mem_busy             = (state_q == ST_WAIT);
   assign dmem_req             = req_q;
   assign dmem_we              = we_q;
   assign dmem_addr            = addr_q;
   assign dmem_be              = be_q;
   assign dmem_wdata           = wdata_q;
   assign wb_data              = wb_data_q;
   assign mem_pipeline_ctl_out = ctl_out_q;
   assign misaligned           = misaligned_q;
   assign bus_error            = bus_error_q;

endmodule
